// File: rtl/rbcp_pkg.sv
// Shared definitions for the RBCP bus multiplexer: FSM state encoding,
// width of the slave-index bus, read-data fill value for writes, and a helper
// that builds the bit mask of the slave-select field inside RBCP_ADDR.
package rbcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Slave-index bus width; the select field in the address may be narrower.
  localparam int SEL_W = 4;

  // RBCP_RD value returned with the ACK of a write transaction.
  localparam logic [7:0] RD_WRITE_FILL = 8'h00;

  // Ones over bits [msb:lsb], zeros elsewhere.
  function automatic logic [31:0] sel_mask(input int msb, input int lsb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i >= lsb) && (i <= msb);
    end
    return m;
  endfunction

endpackage

// File: rtl/rbcp_addr_decode.sv
// Combinational address decoder for the RBCP bus multiplexer.
// Ports: addr (latched RBCP address) in; idx (slave index), valid (idx maps
// to an existing slave) and local_addr (addr with select field zeroed) out.
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic [31:0]      local_addr
);

  localparam int          FW         = SEL_MSB - SEL_LSB + 1;
  localparam logic [31:0] FIELD_MASK = sel_mask(SEL_MSB, SEL_LSB);

  logic [FW-1:0] field;

  assign field      = addr[SEL_MSB:SEL_LSB];
  assign idx        = SEL_W'(field);
  assign valid      = int'(idx) < NUM_SLV;
  assign local_addr = addr & ~FIELD_MASK;

endmodule

// File: rtl/rbcp_bus_mux.sv
// Fans one SiTCP RBCP master out to NUM_SLV register slaves, one transaction
// at a time. Request at cycle t -> slave strobe at t+2 -> RBCP_ACK one cycle
// after the selected slave's ACK. Requests arriving while busy are dropped.
// Ports: CLK/RST_N; RBCP_WE/RE/WD/ADDR in, RBCP_RD/ACK/TMO out (master side);
// S_WE/S_RE/S_WD/S_ADDR out, S_RD/S_ACK in (slave side, slave i at slice i).
// Optional macro RBCP_MUX_TIMEOUT_EN: abort a WAIT after TO_CYC cycles with a
// one-cycle RBCP_TMO pulse; without it WAIT lasts until the slave ACKs.
module rbcp_bus_mux
  import rbcp_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28,
  parameter int TO_CYC  = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RBCP_WE,
  input  logic                 RBCP_RE,
  input  logic [7:0]           RBCP_WD,
  input  logic [31:0]          RBCP_ADDR,
  output logic [7:0]           RBCP_RD,
  output logic                 RBCP_ACK,
  output logic                 RBCP_TMO,
  output logic [NUM_SLV-1:0]   S_WE,
  output logic [NUM_SLV-1:0]   S_RE,
  output logic [7:0]           S_WD,
  output logic [31:0]          S_ADDR,
  input  logic [8*NUM_SLV-1:0] S_RD,
  input  logic [NUM_SLV-1:0]   S_ACK
);

  state_t state_q, state_d;

  // Latched request
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] addr_q, addr_d;

  // Registered outputs
  logic [NUM_SLV-1:0] s_we_q, s_we_d;
  logic [NUM_SLV-1:0] s_re_q, s_re_d;
  logic               ack_q, ack_d;
  logic [7:0]         rd_q, rd_d;
  logic               tmo_q, tmo_d;

  // Decoder outputs
  logic [SEL_W-1:0] dec_idx;
  logic             dec_valid;
  logic [31:0]      dec_local;

  // Selected-slave views
  logic               ack_sel;
  logic [7:0]         rd_sel;
  logic [NUM_SLV-1:0] sel_onehot;

  rbcp_addr_decode #(
    .NUM_SLV (NUM_SLV),
    .SEL_MSB (SEL_MSB),
    .SEL_LSB (SEL_LSB)
  ) u_dec (
    .addr       (addr_q),
    .idx        (dec_idx),
    .valid      (dec_valid),
    .local_addr (dec_local)
  );

  // Pick out the addressed slave's ACK and read data; every other slave's
  // ACK is invisible to the FSM.
  always_comb begin
    ack_sel    = 1'b0;
    rd_sel     = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dec_idx == SEL_W'(i)) begin
        ack_sel       = S_ACK[i];
        rd_sel        = S_RD[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef RBCP_MUX_TIMEOUT_EN
  localparam int CNT_W = (TO_CYC > 255) ? $clog2(TO_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC != 0);
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    re_d    = re_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    s_we_d  = '0;
    s_re_d  = '0;
    ack_d   = 1'b0;
    rd_d    = '0;
    tmo_d   = 1'b0;
`ifdef RBCP_MUX_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (RBCP_WE || RBCP_RE) begin
          // Simultaneous WE and RE is treated as a write.
          we_d    = RBCP_WE;
          re_d    = RBCP_RE & ~RBCP_WE;
          wd_d    = RBCP_WD;
          addr_d  = RBCP_ADDR;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_valid) begin
          // Strobe is registered, so it is high only in the first WAIT cycle.
          s_we_d  = we_q ? sel_onehot : '0;
          s_re_d  = re_q ? sel_onehot : '0;
          state_d = ST_WAIT;
`ifdef RBCP_MUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // ACK is checked first so it wins over a same-cycle timeout.
        if (ack_sel) begin
          ack_d   = 1'b1;
          rd_d    = re_q ? rd_sel : RD_WRITE_FILL;
          state_d = ST_DONE;
        end
`ifdef RBCP_MUX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wd_q    <= '0;
      addr_q  <= '0;
      s_we_q  <= '0;
      s_re_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      tmo_q   <= 1'b0;
`ifdef RBCP_MUX_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      s_we_q  <= s_we_d;
      s_re_q  <= s_re_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
`ifdef RBCP_MUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign S_WE     = s_we_q;
  assign S_RE     = s_re_q;
  assign S_WD     = wd_q;
  assign S_ADDR   = dec_local;
  assign RBCP_ACK = ack_q;
  assign RBCP_RD  = rd_q;
`ifdef RBCP_MUX_TIMEOUT_EN
  assign RBCP_TMO = tmo_q;
`else
  assign RBCP_TMO = 1'b0;
  logic unused_tmo;
  assign unused_tmo = tmo_q;
`endif

endmodule
